stack_sequencer: RTL
====================

# stack_sequencer

Control block for the CPU return stack. Turns decoded CALL/RET strobes and an interrupt request into push/pop/clear commands for the return-stack storage and PC-redirect commands for fetch. Tracks stack depth, arbitrates between instruction calls and interrupt entry, and raises a sticky trap on stack overflow, underflow or illegal strobe combinations. Sits between instruction decode and the return-stack array, beside the program counter.

## Interface
Parameters:
- PC_WIDTH, 8: program-address width.
- DEPTH, 16: return-stack entries; must match the storage array.
- IRQ_VECTOR, 8'h04: PC loaded on interrupt entry.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- call  in  1  decoded CALL for the instruction at `pc`.
- ret  in  1  decoded RET for the instruction at `pc`.
- pc  in  PC_WIDTH  address of the current instruction.
- call_target  in  PC_WIDTH  CALL destination.
- stack_top  in  PC_WIDTH  current top-of-stack read data from the storage.
- irq_req  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse when the interrupt is accepted.
- stack_push  out  1  write `push_addr` at the top and increment.
- stack_pop  out  1  decrement the top.
- stack_clear  out  1  reset the storage pointer.
- push_addr  out  PC_WIDTH  data to push.
- pc_load  out  1  fetch must load `pc_next` at the next edge.
- pc_next  out  PC_WIDTH  redirect address.
- stall  out  1  fetch holds `pc`; decode strobes are ignored.
- depth  out  $clog2(DEPTH+1)  number of occupied entries.
- full  out  1  asserted when `depth` == DEPTH.
- empty  out  1  asserted when `depth` == 0.
- isr_active  out  1  interrupt handler is running.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  fault code: 1 = overflow, 2 = underflow, 3 = CALL and RET together.

## Operation
- States: RUN, IRQ_PUSH, TRAP.
- Strobe timing:
  - `stack_push`, `stack_pop`, `pc_load`, `pc_next`, `push_addr`, `irq_ack` and `stall` are combinational from the state and inputs.
  - All of them are forced to 0 while `reset` is high.
- RUN, evaluated in priority order:
  - `call` and `ret` both high: go to TRAP with cause 3. No strobes.
  - `call` with `full`: go to TRAP with cause 1. No push.
  - `call` otherwise: `stack_push`=1, `push_addr`=`pc`+1 (modulo 2^PC_WIDTH, so all-ones wraps to 0), `pc_load`=1, `pc_next`=`call_target`. `depth` increments.
  - `ret` with `empty`: go to TRAP with cause 2.
  - `ret` otherwise: `stack_pop`=1, `pc_load`=1, `pc_next`=`stack_top`. `depth` decrements.
    - If `isr_active` is set and `depth`==`isr_depth`, clear `isr_active` at the same edge.
  - `irq_req` with `isr_active`=0 and not `full`: `irq_ack`=1, `stall`=1, latch `pc` into `saved_pc`, go to IRQ_PUSH.
    - The interrupted instruction is not executed; it is re-fetched after the handler returns.
  - `irq_req` otherwise: held pending. It is level-sensitive and is not latched by this block.
- IRQ_PUSH (one cycle):
  - Outputs: `stall`=1, `stack_push`=1, `push_addr`=`saved_pc`, `pc_load`=1, `pc_next`=IRQ_VECTOR.
  - At the edge: `depth`+1, `isr_active`←1, `isr_depth`←`depth`+1, return to RUN.
  - `call`/`ret` are ignored in this state.
- TRAP:
  - Outputs: `stall`=1, `trap`=1, `trap_cause` frozen, no stack or PC strobes, `irq_ack`=0.
  - Exit only via `reset`.
- Interrupts are not nested: while `isr_active` is set, `irq_req` stays pending.
- `depth` never exceeds DEPTH and never goes below 0, by construction.

## Timing
- Reset values:
  - state = RUN; `depth` = 0; `isr_active` = 0; `isr_depth` = 0; `saved_pc` = 0; `trap` = 0; `trap_cause` = 0.
  - `stack_clear` = 1. It is registered and drops after the first rising edge following reset release.
  - `empty` = 1, `full` = 0. All combinational strobes are 0 while reset is held.
- Latencies:
  - CALL/RET: zero-latency strobes; `depth` and the storage update at the same rising edge.
  - Interrupt: `irq_ack` in cycle N, push plus vector load in cycle N+1, first handler fetch in cycle N+2.
  - `stall` is high for cycles N and N+1.
- Trap entry: takes effect at the edge after the offending cycle. `trap` is a registered output.
- `full`/`empty` are decoded from the registered `depth`.
- Reset mid-IRQ_PUSH: no push occurs and all state returns to reset values.

## Test plan
- Reset, then CALL at `pc`=8'h10 with `call_target`=8'h40 -> `stack_push`=1, `push_addr`=8'h11, `pc_next`=8'h40; `depth` 0→1. Then RET with `stack_top`=8'h11 -> `stack_pop`=1, `pc_next`=8'h11, `depth`=0, `empty`=1.
- 16 consecutive CALLs -> `full`=1, `depth`=16. A 17th CALL -> no push, `trap`=1, `trap_cause`=1, `stall` stays 1 until reset.
- RET with `depth`=0 -> `trap`=1, `trap_cause`=2, no `stack_pop`. Same-cycle `call`+`ret` -> `trap_cause`=3.
- `irq_req`=1 in RUN at `pc`=8'h22 -> `irq_ack` pulse in cycle N, push 8'h22 and `pc_next`=8'h04 in N+1, `isr_active`=1. A second `irq_req` is held off. Handler CALL/RET keeps `isr_active`=1. The final RET to `depth` 0 pops 8'h22 and clears `isr_active`.
- `irq_req` and `call` in the same cycle -> CALL executes, no `irq_ack`. The interrupt is accepted in the next idle cycle.
- CALL at `pc`=8'hFF -> `push_addr`=8'h00. Assert `reset` during IRQ_PUSH -> `depth`=0, `isr_active`=0, `stack_clear`=1 for one cycle after release.

Source files
------------

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - return-stack control: CALL/RET/IRQ sequencing, depth tracking, sticky trap
module stack_sequencer #(
    parameter int                  PC_WIDTH   = 8,
    parameter int                  DEPTH      = 16,
    parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = 8'h04
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         call,
    input  logic                         ret,
    input  logic [PC_WIDTH-1:0]          pc,
    input  logic [PC_WIDTH-1:0]          call_target,
    input  logic [PC_WIDTH-1:0]          stack_top,
    input  logic                         irq_req,
    output logic                         irq_ack,
    output logic                         stack_push,
    output logic                         stack_pop,
    output logic                         stack_clear,
    output logic [PC_WIDTH-1:0]          push_addr,
    output logic                         pc_load,
    output logic [PC_WIDTH-1:0]          pc_next,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         isr_active,
    output logic                         trap,
    output logic [1:0]                   trap_cause
);

    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_IRQ_PUSH = 2'd1;
    localparam logic [1:0] S_TRAP     = 2'd2;

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [1:0]          cause_next;
    logic [DW-1:0]       isr_depth;
    logic [PC_WIDTH-1:0] saved_pc;
    logic                latch_pc;
    logic                isr_clear;

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == '0);

    always_comb begin
        next_state = state;
        cause_next = 2'd0;
        latch_pc   = 1'b0;
        isr_clear  = 1'b0;
        irq_ack    = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        push_addr  = '0;
        pc_load    = 1'b0;
        pc_next    = '0;
        stall      = 1'b0;

        case (state)
            S_RUN: begin
                if (call && ret) begin
                    next_state = S_TRAP;
                    cause_next = 2'd3;
                end else if (call) begin
                    if (full) begin
                        next_state = S_TRAP;
                        cause_next = 2'd1;
                    end else begin
                        stack_push = 1'b1;
                        push_addr  = pc + 1'b1;
                        pc_load    = 1'b1;
                        pc_next    = call_target;
                    end
                end else if (ret) begin
                    if (empty) begin
                        next_state = S_TRAP;
                        cause_next = 2'd2;
                    end else begin
                        stack_pop = 1'b1;
                        pc_load   = 1'b1;
                        pc_next   = stack_top;
                        isr_clear = isr_active && (depth == isr_depth);
                    end
                end else if (irq_req && !isr_active && !full) begin
                    // The interrupted instruction is re-fetched on return, so save its own pc.
                    irq_ack    = 1'b1;
                    stall      = 1'b1;
                    latch_pc   = 1'b1;
                    next_state = S_IRQ_PUSH;
                end
            end
            S_IRQ_PUSH: begin
                stall      = 1'b1;
                stack_push = 1'b1;
                push_addr  = saved_pc;
                pc_load    = 1'b1;
                pc_next    = IRQ_VECTOR;
                next_state = S_RUN;
            end
            default: begin
                stall = 1'b1;
            end
        endcase

        if (reset) begin
            irq_ack    = 1'b0;
            stack_push = 1'b0;
            stack_pop  = 1'b0;
            push_addr  = '0;
            pc_load    = 1'b0;
            pc_next    = '0;
            stall      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            depth       <= '0;
            isr_active  <= 1'b0;
            isr_depth   <= '0;
            saved_pc    <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'd0;
            stack_clear <= 1'b1;
        end else begin
            stack_clear <= 1'b0;
            state       <= next_state;
            if (stack_push)
                depth <= depth + 1'b1;
            else if (stack_pop)
                depth <= depth - 1'b1;
            if (latch_pc)
                saved_pc <= pc;
            if (state == S_IRQ_PUSH) begin
                isr_active <= 1'b1;
                isr_depth  <= depth + 1'b1;
            end else if (isr_clear) begin
                isr_active <= 1'b0;
            end
            if (state == S_RUN && next_state == S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_next;
            end
        end
    end

endmodule
